// File: rtl/mont_host_ctrl_if.sv
// mont_host_ctrl_if: host-side bundle of command, operand-stream and result-stream signals
// Parameter: DATA_W - stream word width
// Signals:   cmd_valid/cmd_ready/cmd_op - command handshake (op 0=A, 1=B, 2=M, 3=execute)
//            s_valid/s_ready/s_data     - operand word stream into the controller
//            m_valid/m_ready/m_data/m_last - result word stream out of the controller
//            busy, err                  - controller status
// Modports:  master = host side, slave = controller side
interface mont_host_ctrl_if #(
    parameter int DATA_W = 32
) ();
    logic              cmd_valid, cmd_ready;
    logic [1:0]        cmd_op;
    logic              s_valid, s_ready;
    logic [DATA_W-1:0] s_data;
    logic              m_valid, m_ready, m_last;
    logic [DATA_W-1:0] m_data;
    logic              busy, err;
    modport master (
        output cmd_valid, cmd_op, s_valid, s_data, m_ready,
        input  cmd_ready, s_ready, m_valid, m_data, m_last, busy, err
    );
    modport slave (
        input  cmd_valid, cmd_op, s_valid, s_data, m_ready,
        output cmd_ready, s_ready, m_valid, m_data, m_last, busy, err
    );
endinterface

// File: rtl/mont_host_ctrl.sv
// mont_host_ctrl: host-side sequencer that loads A/B/M word-serially, starts a montgomery core and streams its result back
// Ports: clk, resetn (async, active-low)
//        h           - slave end of mont_host_ctrl_if (command, operand stream, result stream, busy, err)
//        core_start  - one-cycle start pulse to the core
//        core_in_a/b/m - operand registers driven straight to the core
//        core_result, core_done - core result and level done (core clears done on the start edge)
// Option: MONT_HOST_CTRL_TIMEOUT_EN adds a WAIT watchdog of TIMEOUT_CYC cycles that sets sticky err
module mont_host_ctrl #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 1024,
    parameter int NWORDS = OP_W / DATA_W
`ifdef MONT_HOST_CTRL_TIMEOUT_EN
    , parameter int TIMEOUT_CYC = 1048576
`endif
) (
    input  logic            clk,
    input  logic            resetn,
    mont_host_ctrl_if.slave h,
    output logic            core_start,
    output logic [OP_W-1:0] core_in_a,
    output logic [OP_W-1:0] core_in_b,
    output logic [OP_W-1:0] core_in_m,
    input  logic [OP_W-1:0] core_result,
    input  logic            core_done
);
    localparam int CW = NWORDS > 1 ? $clog2(NWORDS) : 1;
    typedef enum logic [2:0] {IDLE, LOAD, START, WAIT, STREAM} state_t;
    state_t          state_q, state_d;
    logic [OP_W-1:0] a_q, a_d, b_q, b_d, m_q, m_d, res_q, res_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      sel_q, sel_d;
    logic            last_w, tmo_hit;
    assign last_w    = cnt_q == CW'(NWORDS - 1);
    assign core_in_a = a_q;
    assign core_in_b = b_q;
    assign core_in_m = m_q;
`ifdef MONT_HOST_CTRL_TIMEOUT_EN
    localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_q, err_d;
    // counter sits at zero outside WAIT, so it restarts from zero on every WAIT entry
    always_comb begin
        tmo_d = state_q == WAIT ? tmo_q + 1'b1 : '0;
        err_d = tmo_hit ? 1'b1 : (state_q == IDLE && h.cmd_valid && h.cmd_op == 2'd3) ? 1'b0 : err_q;
    end
    assign tmo_hit = state_q == WAIT && !core_done && tmo_q == TW'(TIMEOUT_CYC - 1);
    assign h.err   = err_q;
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            tmo_q <= '0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign h.err   = 1'b0;
`endif
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            m_q     <= m_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
        end
    end
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        m_d     = m_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: if (h.cmd_valid) begin
                sel_d   = h.cmd_op;
                cnt_d   = '0;
                state_d = h.cmd_op == 2'd3 ? START : LOAD;
            end
            LOAD: if (h.s_valid) begin
                if (sel_q == 2'd0) a_d[cnt_q*DATA_W +: DATA_W] = h.s_data;
                if (sel_q == 2'd1) b_d[cnt_q*DATA_W +: DATA_W] = h.s_data;
                if (sel_q == 2'd2) m_d[cnt_q*DATA_W +: DATA_W] = h.s_data;
                cnt_d   = cnt_q + 1'b1;
                state_d = last_w ? IDLE : LOAD;
            end
            START: state_d = WAIT;
            WAIT: if (core_done) begin
                res_d   = core_result;
                cnt_d   = '0;
                state_d = STREAM;
            end else if (tmo_hit) begin
                state_d = IDLE;
            end
            STREAM: if (h.m_ready) begin
                res_d   = res_q >> DATA_W;
                cnt_d   = cnt_q + 1'b1;
                state_d = last_w ? IDLE : STREAM;
            end
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        h.cmd_ready = state_q == IDLE;
        h.s_ready   = state_q == LOAD;
        h.m_valid   = state_q == STREAM;
        h.m_data    = state_q == STREAM ? res_q[DATA_W-1:0] : '0;
        h.m_last    = state_q == STREAM && last_w;
        h.busy      = state_q != IDLE;
        core_start  = state_q == START;
    end
endmodule

// File: tb/tb_mont_host_ctrl.sv
// tb_mont_host_ctrl: directed scoreboard bench for mont_host_ctrl with a behavioural core model
module tb_mont_host_ctrl;
    localparam int DW = 32;
    localparam int OW = 1024;
    localparam int NW = OW / DW;
`ifdef MONT_HOST_CTRL_TIMEOUT_EN
    localparam int TMO = 64;
`endif
    logic clk = 1'b0, resetn = 1'b0;
    logic core_start, core_done;
    logic [OW-1:0] core_in_a, core_in_b, core_in_m, core_result;
    logic [OW-1:0] core_val = '0;
    int core_lat = 0, core_cnt;
    int passed = 0, total = 0;
    logic [DW-1:0] sbq[$];
    mont_host_ctrl_if #(.DATA_W(DW)) hif ();
`ifdef MONT_HOST_CTRL_TIMEOUT_EN
    mont_host_ctrl #(.DATA_W(DW), .OP_W(OW), .TIMEOUT_CYC(TMO)) dut (
`else
    mont_host_ctrl #(.DATA_W(DW), .OP_W(OW)) dut (
`endif
        .clk(clk), .resetn(resetn), .h(hif), .core_start(core_start),
        .core_in_a(core_in_a), .core_in_b(core_in_b), .core_in_m(core_in_m),
        .core_result(core_result), .core_done(core_done)
    );
    always #5 clk = ~clk;
    // core model: clears done on the start edge, raises it core_lat cycles later; core_lat=0 never completes
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            core_done   <= 1'b0;
            core_cnt    <= 0;
            core_result <= '0;
        end else if (core_start) begin
            core_done <= 1'b0;
            core_cnt  <= core_lat;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_done   <= 1'b1;
                core_result <= core_val;
            end
        end
    end
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask
    task automatic do_cmd(input logic [1:0] op);
        int n = 0;
        while (!hif.cmd_ready && n < 1000) begin
            tick();
            n++;
        end
        check("cmd_ready_wait", hif.cmd_ready, 1);
        hif.cmd_valid = 1'b1;
        hif.cmd_op    = op;
        tick();
        hif.cmd_valid = 1'b0;
    endtask
    task automatic load(input logic [1:0] op, input logic [OW-1:0] v, input bit gap);
        do_cmd(op);
        for (int k = 0; k < NW; k++) begin
            if (gap) begin
                hif.s_valid = 1'b0;
                hif.s_data  = '1;
                tick();
            end
            hif.s_valid = 1'b1;
            hif.s_data  = v[k*DW +: DW];
            tick();
        end
        hif.s_valid = 1'b0;
    endtask
    task automatic execute(input logic [OW-1:0] val, input int lat);
        core_val = val;
        core_lat = lat;
        for (int k = 0; k < NW; k++) sbq.push_back(val[k*DW +: DW]);
        check("start_before", core_start, 0);
        do_cmd(2'd3);
        check("start_pulse", core_start, 1);
        tick();
        check("start_once", core_start, 0);
    endtask
    task automatic async_reset();
        #2 resetn = 1'b0;
        #1;
        check("rst_busy", hif.busy, 0);
        check("rst_mvalid", hif.m_valid, 0);
        check("rst_mdata", hif.m_data, 0);
        check("rst_mlast", hif.m_last, 0);
        check("rst_start", core_start, 0);
        check("rst_err", hif.err, 0);
        check("rst_regs", |{core_in_a, core_in_b, core_in_m}, 0);
        sbq.delete();
        hif.m_ready = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        tick();
        check("post_rst_cmd_ready", hif.cmd_ready, 1);
        check("post_rst_mvalid", hif.m_valid, 0);
        check("post_rst_regs", |{core_in_a, core_in_b, core_in_m}, 0);
    endtask
    task automatic drain(input int stall_at, input int stall_len, input int abort_at);
        int beats = 0, n = 0;
        logic [DW-1:0] hd;
        logic hl;
        hif.m_ready = 1'b1;
        while (beats < NW && n < 5000) begin
            if (hif.m_valid) begin
                if (beats == abort_at) begin
                    hif.m_ready = 1'b0;
                    async_reset();
                    return;
                end
                if (beats == stall_at) begin
                    hif.m_ready = 1'b0;
                    hd = hif.m_data;
                    hl = hif.m_last;
                    repeat (stall_len) begin
                        tick();
                        check("stall_valid", hif.m_valid, 1);
                        check("stall_data", hif.m_data, hd);
                        check("stall_last", hif.m_last, hl);
                    end
                    hif.m_ready = 1'b1;
                end
                check("m_data", hif.m_data, sbq.pop_front());
                check("m_last", hif.m_last, beats == NW - 1);
                beats++;
            end
            tick();
            n++;
        end
        hif.m_ready = 1'b0;
        check("beat_count", beats, NW);
        check("idle_after_stream", hif.busy, 0);
        check("mvalid_after_stream", hif.m_valid, 0);
    endtask
    initial begin
        logic [OW-1:0] v, ones;
        bit mv_seen;
        hif.cmd_valid = 1'b0;
        hif.cmd_op    = '0;
        hif.s_valid   = 1'b0;
        hif.s_data    = '0;
        hif.m_ready   = 1'b0;
        repeat (3) tick();
        check("reset_busy", hif.busy, 0);
        check("reset_cmd_ready", hif.cmd_ready, 1);
        check("reset_mvalid", hif.m_valid, 0);
        check("reset_err", hif.err, 0);
        check("reset_regs", |{core_in_a, core_in_b, core_in_m}, 0);
        @(negedge clk);
        resetn = 1'b1;
        tick();
        ones = '1;
        load(2'd0, OW'(1), 1'b0);
        load(2'd1, OW'(1), 1'b0);
        load(2'd2, ones, 1'b0);
        check("a_low", core_in_a[63:0], 64'd1);
        check("a_high", |core_in_a[OW-1:64], 0);
        check("b_low", core_in_b[63:0], 64'd1);
        check("m_ones", &core_in_m, 1);
        execute(OW'(16'h1234), 100);
        drain(-1, 0, -1);
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = $urandom();
        load(2'd0, v, 1'b1);
        check("cmd_ready_after_load", hif.cmd_ready, 1);
        check("s_ready_idle", hif.s_ready, 0);
        for (int k = 0; k < NW; k++) check("a_word", core_in_a[k*DW +: DW], v[k*DW +: DW]);
        check("b_kept", core_in_b[63:0], 64'd1);
        hif.s_valid = 1'b1;
        hif.s_data  = 32'hDEADBEEF;
        repeat (2) tick();
        hif.s_valid = 1'b0;
        check("no_consume_idle", core_in_a[DW-1:0], v[DW-1:0]);
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = $urandom();
        execute(v, 7);
        drain(10, 5, -1);
        // done is still high from the previous run; the new result must come from the new completion
        check("stale_done_high", core_done, 1);
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = $urandom();
        execute(v, 20);
        repeat (5) tick();
        check("stale_done_ignored", hif.m_valid, 0);
        drain(-1, 0, -1);
        mv_seen = 1'b0;
        execute(OW'(64'hCAFE), 0);
        sbq.delete();
`ifdef MONT_HOST_CTRL_TIMEOUT_EN
        repeat (TMO - 1) begin
            tick();
            mv_seen |= hif.m_valid;
        end
        check("tmo_still_wait", hif.busy, 1);
        check("tmo_err_low", hif.err, 0);
        tick();
        check("tmo_idle", hif.busy, 0);
        check("tmo_err", hif.err, 1);
        repeat (5) tick();
        check("tmo_err_sticky", hif.err, 1);
        check("tmo_no_mvalid", mv_seen, 0);
        execute(OW'(64'h55), 3);
        check("err_cleared", hif.err, 0);
        drain(-1, 0, -1);
`else
        repeat (10000) begin
            tick();
            mv_seen |= hif.m_valid;
        end
        check("wait_forever_busy", hif.busy, 1);
        check("wait_forever_err", hif.err, 0);
        check("wait_no_mvalid", mv_seen, 0);
        async_reset();
`endif
        load(2'd0, OW'(64'h77), 1'b0);
        execute(OW'(1), 0);
        repeat (3) tick();
        async_reset();
        load(2'd1, OW'(64'h99), 1'b0);
        for (int k = 0; k < NW; k++) v[k*DW +: DW] = $urandom();
        execute(v, 4);
        drain(-1, 0, 7);
        repeat (40) tick();
        check("no_partial_result", hif.m_valid, 0);
        check("idle_final", hif.cmd_ready, 1);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
